// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder (dmem_responder).
package dmem_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Rotate right by whole bytes so the addressed byte lands at [7:0].
    function automatic logic [WORD_W-1:0] rotate_rd(input logic [WORD_W-1:0] w,
                                                    input logic [1:0] off);
        case (off)
            2'd0:    return w;
            2'd1:    return {w[7:0], w[31:8]};
            2'd2:    return {w[15:0], w[31:16]};
            default: return {w[23:0], w[31:24]};
        endcase
    endfunction

    function automatic logic in_range(input logic [WORD_W-1:0] addr,
                                      input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == '0;
    endfunction

    function automatic logic [LANES-1:0] lane_parity(input logic [WORD_W-1:0] w);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) p[i] = ^w[i*BYTE_W +: BYTE_W];
        return p;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled synchronous RAM with read-old semantics.
// DMEM_PARITY_EN adds one even-parity bit per lane and a mismatch flag.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we_be,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
`ifdef DMEM_PARITY_EN
    ,
    output logic              par_err_c
`endif
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_be[i]) mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
        if (re) rdata <= mem[raddr];
    end

`ifdef DMEM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] rpar;
    logic [LANES-1:0] wpar;

    assign wpar = lane_parity(wdata);

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we_be[i]) par_mem[waddr][i] <= wpar[i];
        end
        if (re) rpar <= par_mem[raddr];
    end

    assign par_err_c = |(rpar ^ lane_parity(rdata));
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the LSU port: handshake, wait states, decode, rotated read.
// Optional lane parity under DMEM_PARITY_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              accept_c;
    logic              acc_c;
    logic [31:0]       acc_addr;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic [LANES-1:0]  we_be;
    logic [WORD_W-1:0] arr_rdata;
    logic              par_err_c;

    assign accept_c = (state == IDLE) && req_valid && req_ready;

    // Array access happens on the edge entering RESP; with no wait states that is the accept edge.
    always_comb begin
        acc_addr  = addr_q;
        acc_be    = be_q;
        acc_wdata = wdata_q;
        acc_c     = 1'b0;
        if (state == IDLE) begin
            acc_addr  = req_addr;
            acc_be    = req_be;
            acc_wdata = req_wdata;
            acc_c     = accept_c && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            acc_c = (cnt == 4'd0);
        end
    end

    assign we_be = (acc_c && in_range(acc_addr, ADDR_W)) ? acc_be : '0;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk      (clk),
        .we_be    (we_be),
        .waddr    (acc_addr[ADDR_W+1:2]),
        .wdata    (acc_wdata),
        .re       (acc_c),
        .raddr    (acc_addr[ADDR_W+1:2]),
        .rdata    (arr_rdata)
`ifdef DMEM_PARITY_EN
        ,
        .par_err_c(par_err_c)
`endif
    );

`ifndef DMEM_PARITY_EN
    assign par_err_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept_c) begin
                        addr_q    <= req_addr;
                        be_q      <= req_be;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                    if (in_range(addr_q, ADDR_W)) begin
                        rsp_rdata <= rotate_rd(arr_rdata, addr_q[1:0]);
                        rsp_err   <= par_err_c;
                    end else begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
